// File: rtl/bmem_burst_responder_if.sv
// Banked burst-memory bus between the cpu (master) and the responder (slave).
// Carries request, write-burst, read-return and protocol-error signals.
interface bmem_burst_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [DATA_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [DATA_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;
    logic                  proto_err;

    modport master (
        output bmem_addr,
        output bmem_read,
        output bmem_write,
        output bmem_wdata,
        input  bmem_ready,
        input  bmem_raddr,
        input  bmem_rdata,
        input  bmem_rvalid,
        input  proto_err
    );

    modport slave (
        input  bmem_addr,
        input  bmem_read,
        input  bmem_write,
        input  bmem_wdata,
        output bmem_ready,
        output bmem_raddr,
        output bmem_rdata,
        output bmem_rvalid,
        output proto_err
    );
endinterface

// File: rtl/bmem_burst_responder.sv
// Burst-memory responder: line storage, 4-beat write bursts, FIFO read queue
// with fixed latency and back-to-back 4-beat read bursts.
module bmem_burst_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LEN    = 4,
    parameter int LINE_COUNT   = 256,
    parameter int READ_LATENCY = 8,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
    bmem_burst_responder_if.slave bus
);
    localparam int OFF = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam int IW  = $clog2(LINE_COUNT);
    localparam int BW  = $clog2(BURST_LEN);
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int DW  = $clog2(READ_LATENCY);
    localparam int LW  = ADDR_WIDTH - OFF;

    typedef logic [LW-1:0] line_t;
    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [DATA_WIDTH-1:0] r_mem [LINE_COUNT*BURST_LEN];

    line_t         r_q_line [QUEUE_DEPTH];
    logic [DW-1:0] r_q_cd   [QUEUE_DEPTH];
    logic [CW-1:0] r_cnt;

    line_t         w_src_line [QUEUE_DEPTH];
    logic [DW-1:0] w_src_cd   [QUEUE_DEPTH];
    line_t         w_q_line_n [QUEUE_DEPTH];
    logic [DW-1:0] w_q_cd_n   [QUEUE_DEPTH];
    logic [CW-1:0] w_cnt_pop;
    logic [CW-1:0] w_cnt_n;

    logic          r_live;
    logic [BW-1:0] r_wbeat;
    line_t         r_wline;
    logic          r_err;

    state_t                r_state;
    logic [BW-1:0]         r_beat;
    logic [IW-1:0]         r_bidx;
    logic                  r_rvalid;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic             w_ready;
    logic             w_in_burst;
    line_t            w_line;
    logic             w_wstart;
    logic             w_wbeat_ok;
    logic             w_push;
    logic             w_err;
    logic             w_we;
    logic [IW+BW-1:0] w_widx;
    logic             w_last;
    logic             w_pop;
    logic             w_idle_go;
    logic             w_next_go;

    // ready stays low until the first edge after reset release
    assign w_ready    = r_live && (r_cnt < CW'(QUEUE_DEPTH));
    assign w_in_burst = (r_wbeat != '0);
    assign w_line     = bus.bmem_addr[ADDR_WIDTH-1:OFF];
    assign w_wstart   = bus.bmem_write && w_ready && !w_in_burst;
    assign w_wbeat_ok = bus.bmem_write && w_in_burst;
    assign w_push     = bus.bmem_read && !bus.bmem_write
                        && w_ready && !w_in_burst;

    assign w_err = (bus.bmem_read && !w_push)
                 || (bus.bmem_write && !w_ready && !w_in_burst)
                 || (w_in_burst && !bus.bmem_write)
                 || (w_wbeat_ok && (w_line != r_wline));

    assign w_we   = w_wstart || w_wbeat_ok;
    assign w_widx = w_wstart ? {w_line[IW-1:0], {BW{1'b0}}}
                             : {r_wline[IW-1:0], r_wbeat};

    assign w_last    = (r_state == S_BURST)
                       && (r_beat == BW'(BURST_LEN - 1));
    assign w_pop     = w_last;
    assign w_idle_go = (r_state == S_IDLE) && (r_cnt != '0)
                       && (r_q_cd[0] == '0);
    assign w_next_go = (r_cnt > CW'(1)) && (r_q_cd[1] == '0);

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= bus.bmem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_wbeat <= '0;
            r_wline <= '0;
            r_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_err) r_err <= 1'b1;
            if (w_wstart) begin
                r_wbeat <= BW'(1);
                r_wline <= w_line;
            end else if (w_wbeat_ok) begin
                r_wbeat <= (r_wbeat == BW'(BURST_LEN - 1))
                           ? '0 : r_wbeat + BW'(1);
            end else if (w_in_burst) begin
                r_wbeat <= '0;
            end
        end
    end

    // Shift on pop, age every entry, then append at the new tail
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_src_line[i] = r_q_line[i];
            w_src_cd[i]   = r_q_cd[i];
        end
        if (w_pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                w_src_line[i] = r_q_line[i+1];
                w_src_cd[i]   = r_q_cd[i+1];
            end
            w_src_line[QUEUE_DEPTH-1] = '0;
            w_src_cd[QUEUE_DEPTH-1]   = '0;
        end
        w_cnt_pop = r_cnt - CW'(w_pop);
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_q_line_n[i] = w_src_line[i];
            w_q_cd_n[i]   = (w_src_cd[i] != '0)
                            ? w_src_cd[i] - DW'(1) : '0;
            if (w_push && (CW'(i) == w_cnt_pop)) begin
                w_q_line_n[i] = w_line;
                w_q_cd_n[i]   = DW'(READ_LATENCY - 1);
            end
        end
        w_cnt_n = w_cnt_pop + CW'(w_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_line[i] <= '0;
                r_q_cd[i]   <= '0;
            end
        end else begin
            r_cnt <= w_cnt_n;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_line[i] <= w_q_line_n[i];
                r_q_cd[i]   <= w_q_cd_n[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_bidx   <= '0;
            r_rvalid <= 1'b0;
            r_raddr  <= '0;
            r_rdata  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_idle_go) begin
                        r_state  <= S_BURST;
                        r_beat   <= '0;
                        r_bidx   <= r_q_line[0][IW-1:0];
                        r_rvalid <= 1'b1;
                        r_raddr  <= {r_q_line[0], {OFF{1'b0}}};
                        r_rdata  <= r_mem[{r_q_line[0][IW-1:0],
                                           {BW{1'b0}}}];
                    end
                end
                S_BURST: begin
                    if (!w_last) begin
                        r_beat  <= r_beat + BW'(1);
                        r_rdata <= r_mem[{r_bidx, r_beat + BW'(1)}];
                    end else if (w_next_go) begin
                        r_beat  <= '0;
                        r_bidx  <= r_q_line[1][IW-1:0];
                        r_raddr <= {r_q_line[1], {OFF{1'b0}}};
                        r_rdata <= r_mem[{r_q_line[1][IW-1:0],
                                          {BW{1'b0}}}];
                    end else begin
                        r_state  <= S_IDLE;
                        r_rvalid <= 1'b0;
                        r_raddr  <= '0;
                        r_rdata  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bmem_ready  = w_ready;
    assign bus.bmem_raddr  = r_raddr;
    assign bus.bmem_rdata  = r_rdata;
    assign bus.bmem_rvalid = r_rvalid;
    assign bus.proto_err   = r_err;
endmodule

// File: tb/tb_bmem_burst_responder.sv
// Directed bench for bmem_burst_responder: writes, latency, queueing,
// aliasing, aborted bursts, read/write collision and mid-burst reset.
module tb_bmem_burst_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bmem_burst_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

    bmem_burst_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [63:0] A_BASE = 64'hA0A0_0000_0000_0000;
    localparam logic [63:0] B_BASE = 64'hB0B0_0000_0000_0000;
    localparam logic [63:0] C_BASE = 64'hC0C0_0000_0000_0000;
    localparam logic [63:0] D_BASE = 64'hD0D0_0000_0000_0000;
    localparam logic [63:0] E_BASE = 64'hE0E0_0000_0000_0000;
    localparam logic [63:0] Q_BASE = 64'h3000_0000_0000_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr_line(input logic [31:0] a, input logic [63:0] base);
        bus.bmem_addr  = a;
        bus.bmem_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.bmem_wdata = base + 64'(i);
            tick();
        end
        bus.bmem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.bmem_addr = a;
        bus.bmem_read = 1'b1;
        tick();
        bus.bmem_read = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_run++;
        if (bus.bmem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready got=%b exp=0", bus.bmem_ready);
        end
        n_run++;
        if (bus.bmem_rvalid !== 1'b0 || bus.bmem_raddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rvalid got=%b/%h exp=0/0",
                     bus.bmem_rvalid, bus.bmem_raddr);
        end
        n_run++;
        if (bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err got=%b exp=0", bus.proto_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_run++;
        if (bus.bmem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_ready got=%b exp=1", bus.bmem_ready);
        end
    endtask

    task automatic test_write_read();
        logic [63:0] exp_d;
        wr_line(32'h100, A_BASE);
        rd(32'h100);
        for (int j = 1; j <= 12; j++) begin
            tick();
            n_run++;
            if (bus.bmem_rvalid !== (j >= 8 && j <= 11)) begin
                n_fail++;
                $display("FAIL wr_rd_rvalid j=%0d got=%b", j, bus.bmem_rvalid);
            end
            if (j >= 8 && j <= 11) begin
                exp_d = A_BASE + 64'(j - 8);
                n_run++;
                if (bus.bmem_raddr !== 32'h100 || bus.bmem_rdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL wr_rd_data j=%0d got=%h/%h exp=100/%h",
                             j, bus.bmem_raddr, bus.bmem_rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_d;
        logic [31:0] exp_a;
        int b;
        for (int i = 0; i < 4; i++)
            wr_line(32'(i * 32), Q_BASE + 64'(i * 256));
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 32));
            n_run++;
            if (bus.bmem_ready !== (i < 3)) begin
                n_fail++;
                $display("FAIL b2b_ready_fill i=%0d got=%b", i, bus.bmem_ready);
            end
        end
        for (int j = 4; j <= 25; j++) begin
            tick();
            n_run++;
            if (bus.bmem_ready !== (j >= 12)) begin
                n_fail++;
                $display("FAIL b2b_ready j=%0d got=%b", j, bus.bmem_ready);
            end
            n_run++;
            if (bus.bmem_rvalid !== (j >= 8 && j <= 23)) begin
                n_fail++;
                $display("FAIL b2b_rvalid j=%0d got=%b", j, bus.bmem_rvalid);
            end
            if (j >= 8 && j <= 23) begin
                b = (j - 8) / 4;
                exp_a = 32'(b * 32);
                exp_d = Q_BASE + 64'(b * 256) + 64'((j - 8) % 4);
                n_run++;
                if (bus.bmem_raddr !== exp_a || bus.bmem_rdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL b2b_data j=%0d got=%h/%h exp=%h/%h",
                             j, bus.bmem_raddr, bus.bmem_rdata, exp_a, exp_d);
                end
            end
        end
    endtask

    task automatic test_alias();
        logic [63:0] exp_d;
        wr_line(32'h2000, B_BASE);
        rd(32'h0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j >= 8 && j <= 11) begin
                exp_d = B_BASE + 64'(j - 8);
                n_run++;
                if (bus.bmem_rvalid !== 1'b1 || bus.bmem_raddr !== 32'h0
                    || bus.bmem_rdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL alias j=%0d got=%b/%h/%h exp=1/0/%h", j,
                             bus.bmem_rvalid, bus.bmem_raddr, bus.bmem_rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_write_abort();
        logic [63:0] exp_d;
        apply_reset();
        wr_line(32'h300, C_BASE);
        n_run++;
        if (bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_err_pre got=%b exp=0", bus.proto_err);
        end
        bus.bmem_addr  = 32'h300;
        bus.bmem_write = 1'b1;
        bus.bmem_wdata = D_BASE;
        tick();
        bus.bmem_wdata = D_BASE + 64'd1;
        tick();
        bus.bmem_write = 1'b0;
        tick();
        n_run++;
        if (bus.proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_err got=%b exp=1", bus.proto_err);
        end
        rd(32'h300);
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j >= 8 && j <= 11) begin
                exp_d = ((j - 8) < 2 ? D_BASE : C_BASE) + 64'(j - 8);
                n_run++;
                if (bus.bmem_rvalid !== 1'b1 || bus.bmem_rdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL abort_data j=%0d got=%b/%h exp=1/%h",
                             j, bus.bmem_rvalid, bus.bmem_rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_rw_collision();
        logic [63:0] exp_d;
        apply_reset();
        bus.bmem_addr  = 32'h400;
        bus.bmem_read  = 1'b1;
        bus.bmem_write = 1'b1;
        bus.bmem_wdata = E_BASE;
        tick();
        bus.bmem_read = 1'b0;
        n_run++;
        if (bus.proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_err got=%b exp=1", bus.proto_err);
        end
        for (int i = 1; i < 4; i++) begin
            bus.bmem_wdata = E_BASE + 64'(i);
            tick();
        end
        bus.bmem_write = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            n_run++;
            if (bus.bmem_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rw_noburst j=%0d got=%b exp=0", j, bus.bmem_rvalid);
            end
        end
        rd(32'h400);
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j >= 8 && j <= 11) begin
                exp_d = E_BASE + 64'(j - 8);
                n_run++;
                if (bus.bmem_rvalid !== 1'b1 || bus.bmem_rdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL rw_data j=%0d got=%b/%h exp=1/%h",
                             j, bus.bmem_rvalid, bus.bmem_rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        rd(32'h400);
        for (int j = 1; j <= 9; j++) tick();
        n_run++;
        if (bus.bmem_rvalid !== 1'b1 || bus.bmem_rdata !== E_BASE + 64'd1) begin
            n_fail++;
            $display("FAIL mid_pre got=%b/%h exp=1/%h",
                     bus.bmem_rvalid, bus.bmem_rdata, E_BASE + 64'd1);
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if (bus.bmem_rvalid !== 1'b0 || bus.bmem_raddr !== 32'h0
            || bus.bmem_rdata !== 64'h0 || bus.bmem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst got=%b/%h/%h/%b exp=0/0/0/0", bus.bmem_rvalid,
                     bus.bmem_raddr, bus.bmem_rdata, bus.bmem_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_run++;
        if (bus.bmem_ready !== 1'b1 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rel got=%b/%b exp=1/0", bus.bmem_ready, bus.proto_err);
        end
        for (int j = 0; j < 12; j++) begin
            tick();
            n_run++;
            if (bus.bmem_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_nobeat j=%0d got=%b exp=0", j, bus.bmem_rvalid);
            end
        end
    endtask

    initial begin
        bus.bmem_addr  = '0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_write_abort();
        test_rw_collision();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
